// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Each request converts one
// latched sample, and the packed BCD result holds until the next completion edge.
module bin2bcd_conv #(
    parameter int unsigned IN_BITS = 14,
    parameter int unsigned DIGITS  = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  START,
    input  logic [IN_BITS-1:0]    BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVF
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SCR_W = BCD_W + IN_BITS;
    localparam int unsigned CNT_W = $clog2(IN_BITS + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_DEC = pow10(DIGITS) - 64'd1;
    // When every input value fits in DIGITS decimal digits, overflow cannot occur.
    localparam bit OVF_POSSIBLE = (MAX_DEC < (64'd1 << IN_BITS));

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SCR_W-1:0]     r_scr;
    logic [SCR_W-1:0]     w_scr_adj;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_pend;
    logic                 r_busy;
    logic                 r_done;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_ovf;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_shift;
    logic                 w_finish;
    logic                 w_ovf_in;

    // State register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (CE && START)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (CE && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath decode
    always_comb begin
        w_last   = (r_cnt == CNT_W'(IN_BITS));
        w_accept = (r_state == S_IDLE)  && CE && START;
        w_shift  = (r_state == S_SHIFT) && CE && !w_last;
        w_finish = (r_state == S_SHIFT) && CE && w_last;
        w_ovf_in = OVF_POSSIBLE && (64'(BIN) > MAX_DEC);
        w_scr_adj = r_scr;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_scr[IN_BITS + 4*k +: 4] >= 4'd5) begin
                w_scr_adj[IN_BITS + 4*k +: 4] = r_scr[IN_BITS + 4*k +: 4] + 4'd3;
            end
        end
    end

    // Scratch, counter and registered outputs; DONE self-clears regardless of CE
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_scr      <= {BCD_W'(0), BIN};
                r_cnt      <= '0;
                r_ovf_pend <= w_ovf_in;
                r_busy     <= 1'b1;
            end else if (w_shift) begin
                r_scr <= {w_scr_adj[SCR_W-2:0], 1'b0};
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_finish) begin
                r_bcd  <= r_ovf_pend ? {DIGITS{4'h9}} : r_scr[SCR_W-1 -: BCD_W];
                r_ovf  <= r_ovf_pend;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign BCD  = r_bcd;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed self-checking bench for bin2bcd_conv with default parameters
// (14-bit input, 4 digits, 15-cycle latency).
module tb_bin2bcd_conv;

    logic        CLK;
    logic        CLR;
    logic        CE;
    logic        START;
    logic [13:0] BIN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] BCD;
    logic        OVF;

    int          checks;
    int          errors;
    logic [15:0] prev_bcd;

    bin2bcd_conv #(.IN_BITS(14), .DIGITS(4)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .CE    (CE),
        .START (START),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .BCD   (BCD),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: requests a conversion, waits for DONE, checks result and timing.
    task automatic convert(input logic [13:0] b, input logic [15:0] eb, input logic eo,
                           input string tag);
        int   lat;
        logic hold_ok;
        BIN   = b;
        START = 1'b1;
        CE    = 1'b1;
        @(negedge CLK);
        START   = 1'b0;
        lat     = 0;
        hold_ok = 1'b1;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY !== 1'b1 || BCD !== prev_bcd) hold_ok = 1'b0;
            @(negedge CLK);
            lat++;
        end
        check({tag, "_lat"},  32'(lat),     32'd15);
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_bcd"},  32'(BCD),     32'(eb));
        check({tag, "_ovf"},  32'(OVF),     32'(eo));
        check({tag, "_busy"}, 32'(BUSY),    32'd0);
        prev_bcd = eb;
    endtask

    function automatic logic [15:0] model_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        int lat;
        int ndone;
        int nbusy;
        int sweep_v[$];

        checks   = 0;
        errors   = 0;
        prev_bcd = 16'h0000;
        CLR      = 1'b1;
        CE       = 1'b0;
        START    = 1'b0;
        BIN      = '0;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_bcd",  32'(BCD),  32'd0);
        check("rst_ovf",  32'(OVF),  32'd0);

        convert(14'd0, 16'h0000, 1'b0, "zero");
        @(negedge CLK);
        check("done_pulse", 32'(DONE), 32'd0);

        convert(14'd1234,  16'h1234, 1'b0, "v1234");
        convert(14'd9999,  16'h9999, 1'b0, "v9999");
        convert(14'd12000, 16'h9999, 1'b1, "v12000");
        convert(14'd7,     16'h0007, 1'b0, "v7");
        @(negedge CLK);

        // Re-requests and BIN changes mid-conversion are ignored
        BIN   = 14'd42;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        lat   = 0;
        ndone = 0;
        repeat (40) begin
            if (lat == 3 || lat == 8) begin
                START = 1'b1;
                BIN   = 14'd5555;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            lat++;
            if (DONE === 1'b1) ndone++;
        end
        START = 1'b0;
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_bcd",   32'(BCD),   32'h0042);
        check("ign_ovf",   32'(OVF),   32'd0);
        prev_bcd = 16'h0042;

        // CE toggling: 15 enabled edges after the accept edge land at t0+30
        BIN   = 14'd8765;
        START = 1'b1;
        CE    = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        lat   = 0;
        while (DONE !== 1'b1 && lat < 80) begin
            CE = ((lat + 1) % 2 == 0);
            @(negedge CLK);
            lat++;
        end
        check("ce_lat", 32'(lat), 32'd30);
        check("ce_bcd", 32'(BCD), 32'h8765);
        CE = 1'b0;
        @(negedge CLK);
        check("ce_done_clr", 32'(DONE), 32'd0);
        check("ce_bcd_hold", 32'(BCD),  32'h8765);
        CE = 1'b1;

        // Abort after the sixth shift
        BIN   = 14'd1111;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        check("pre_clr_busy", 32'(BUSY), 32'd1);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr_busy", 32'(BUSY), 32'd0);
        check("clr_bcd",  32'(BCD),  32'd0);
        check("clr_ovf",  32'(OVF),  32'd0);
        check("clr_done", 32'(DONE), 32'd0);
        ndone = 0;
        nbusy = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE === 1'b1) ndone++;
            if (BUSY === 1'b1) nbusy++;
        end
        check("clr_no_done", 32'(ndone), 32'd0);
        check("clr_no_busy", 32'(nbusy), 32'd0);
        prev_bcd = 16'h0000;

        // Strided back-to-back sweep including the overflow boundary and max input
        for (int v = 0; v < 16384; v += 7) sweep_v.push_back(v);
        sweep_v.push_back(9999);
        sweep_v.push_back(10000);
        sweep_v.push_back(16383);
        foreach (sweep_v[i]) begin
            convert(14'(sweep_v[i]), model_bcd(sweep_v[i]), 1'(sweep_v[i] > 9999),
                    $sformatf("sw%0d", sweep_v[i]));
        end
        @(negedge CLK);
        check("sweep_end_done", 32'(DONE), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
